serializador_tx: RTL and testbench
==================================

SERIALIZADOR_TX -- requirements
Module: serializador_tx

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately regardless of clk.
REQ-003 enb  input  1  clock enable; when 0, every register holds its value.
REQ-004 clk10  input  1  divided-clock level from the Tx clock generator; toggles every 4 enabled clk cycles, so its period is 8 enabled cycles.
REQ-005 data_in  input  8  parallel byte to be serialized.
REQ-006 valid_in  input  1  data_in holds a valid byte; data_in and valid_in stay stable until data_ack.
REQ-007 ser_out  output  1  serial bit, registered, MSB first.
REQ-008 ser_valid  output  1  ser_out carries a bit of a loaded symbol.
REQ-009 data_ack  output  1  registered one-cycle pulse: the data_in byte was consumed.
REQ-010 is_k  output  1  current symbol is the inserted COM control symbol (see Configuration).
REQ-011 align_err  output  1  sticky flag: clk10 edge arrived out of byte alignment.

Function
REQ-012 Edge detect: clk10_q <= clk10 on every enabled cycle; rise = enb & clk10 & ~clk10_q.
REQ-013 States: IDLE and ACTIVE; a 3-bit bit_cnt counts bits emitted modulo 8.
REQ-014 IDLE: ser_out=0, ser_valid=0; on rise, load a symbol and go to ACTIVE.
REQ-015 Load (cycle with rise): ser_out <= sym[7]; shreg <= sym<<1; bit_cnt <= 1; ser_valid <= 1.
REQ-016 Load symbol: data_in when valid_in=1, with data_ack pulsed high on the next cycle; when valid_in=0, the idle symbol (see Configuration) with no data_ack.
REQ-017 ACTIVE, enabled, no rise: ser_out <= shreg[7]; shreg shifts left, filling with 0; bit_cnt increments, wrapping 7->0.
REQ-018 Latency: the first bit is visible on ser_out 1 cycle after the rise cycle; the full byte takes 8 enabled cycles; with an aligned clk10, the stream has no gaps.
REQ-019 ACTIVE, rise with bit_cnt=0 (aligned): load normally.
REQ-020 ACTIVE, rise with bit_cnt!=0 (misaligned): discard the remaining bits, load the new symbol, and set align_err=1.
REQ-021 ACTIVE, bit_cnt=0 with no rise (underrun): go to IDLE; ser_valid=0 and ser_out=0 next cycle.
REQ-022 enb=0: no shift, no load, no ack; clk10_q holds; outputs hold. A clk10 change seen while enb=0 is evaluated on the next enabled cycle.
REQ-023 align_err clears only on reset.

Reset
REQ-024 When rst=0: state=IDLE; shreg=0, bit_cnt=0, clk10_q=0; ser_out=0, ser_valid=0, data_ack=0, is_k=0, align_err=0.
REQ-025 Reset asserted mid-byte aborts the byte; no ack is issued for it.
REQ-026 After rst release, the first load waits for a fresh 0->1 transition of clk10.

Configuration
REQ-027 Macro IDLE_COM_EN.
- Defined: the idle symbol is COM K28.5 (8'hBC); ser_valid=1 and is_k=1 for those 8 bits.
- Undefined: the idle symbol is 8'h00; ser_valid=0 and ser_out=0 for those 8 bits; is_k is tied 0.

Verification
REQ-028 rst low for 3 cycles, then enb=1, generator-consistent clk10, valid_in=1, data_in=8'hA5 -> ser_out reads 1,0,1,0,0,1,0,1 starting 1 cycle after the rise; one data_ack pulse; align_err=0.
REQ-029 Back-to-back bytes 8'h0F then 8'hF0, each offered on its own ack -> 16 contiguous valid bits 00001111 11110000 with no gap.
REQ-030 valid_in=0 at a rise -> with IDLE_COM_EN defined: 10111100 with is_k=1; without it: ser_valid=0 for 8 cycles; no data_ack in either case.
REQ-031 Inject a clk10 rise 5 cycles after a load -> byte truncated after 5 bits; new byte starts; align_err=1 and stays 1.
REQ-032 Hold clk10 low after one byte -> after 8 bits, ser_valid=0 (IDLE); enb=0 for 4 cycles mid-byte -> ser_out frozen and byte resumes intact; rst pulse mid-byte -> all outputs 0 immediately.

Source files
------------

// File: rtl/serializador_tx.sv
// serializador_tx: parallel byte to MSB-first serial stream, framed by the
// rising edges of the divided Tx clock level clk10 (one byte per clk10 period).
// Optional feature macro: IDLE_COM_EN. When defined, idle slots carry the COM
// K28.5 symbol (8'hBC) as valid bits flagged by is_k. When undefined, idle slots
// are silent (ser_valid=0, ser_out=0) and is_k is constant 0.
module serializador_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic              clk10,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              data_ack,
  output logic              is_k,
  output logic              align_err
);

  // Bit counter wraps naturally, so DATA_W is expected to be a power of two.
  localparam int CNT_W = $clog2(DATA_W);

`ifdef IDLE_COM_EN
  localparam logic [DATA_W-1:0] IDLE_SYM = DATA_W'(8'hBC);
  localparam logic              COM_EN   = 1'b1;
`else
  localparam logic [DATA_W-1:0] IDLE_SYM = '0;
  localparam logic              COM_EN   = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sym;
  logic [CNT_W-1:0]  bit_cnt;
  logic              clk10_q;
  logic              rise;

  // A clk10 rise is only recognised on an enabled cycle; a change during enb=0
  // is picked up on the next enabled cycle because clk10_q holds meanwhile.
  assign rise = enb & clk10 & ~clk10_q;

  // Symbol chosen at a load: the offered byte, or the idle filler when none is offered.
  always_comb begin
    sym = valid_in ? data_in : IDLE_SYM;
  end

  // Serializer FSM: load on every clk10 rise, shift in between, drop to IDLE on underrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      clk10_q   <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      data_ack  <= 1'b0;
      align_err <= 1'b0;
`ifdef IDLE_COM_EN
      is_k      <= 1'b0;
`endif
    end else if (enb) begin
      clk10_q  <= clk10;
      data_ack <= 1'b0;
      if (rise) begin
        // A rise before the current symbol finished truncates it; remember that forever.
        if (state == ACTIVE && bit_cnt != '0) begin
          align_err <= 1'b1;
        end
        state     <= ACTIVE;
        ser_out   <= sym[DATA_W-1];
        shreg     <= sym << 1;
        bit_cnt   <= CNT_W'(1);
        ser_valid <= COM_EN | valid_in;
        data_ack  <= valid_in;
`ifdef IDLE_COM_EN
        is_k      <= ~valid_in;
`endif
      end else if (state == ACTIVE && bit_cnt != '0) begin
        ser_out <= shreg[DATA_W-1];
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else begin
        // Symbol finished with no new rise (or still idle): stream goes quiet.
        state     <= IDLE;
        ser_out   <= 1'b0;
        ser_valid <= 1'b0;
`ifdef IDLE_COM_EN
        is_k      <= 1'b0;
`endif
      end
    end
  end

`ifndef IDLE_COM_EN
  assign is_k = 1'b0;
`endif

endmodule

// File: tb/tb_serializador_tx.sv
// Bench for serializador_tx: table of aligned symbol periods checked through a
// bit scoreboard, plus hand-written enb-pause, misalignment and reset sequences.
module tb_serializador_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       clk10;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ser_out;
  logic       ser_valid;
  logic       data_ack;
  logic       is_k;
  logic       align_err;

  int checks    = 0;
  int failures  = 0;
  int ack_seen  = 0;
  int exp_acks  = 0;

  // Scoreboard entries: {expected is_k, expected ser_out}
  logic [1:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic [7:0] exp_sym;
    logic       exp_vld;
    logic       exp_k;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  serializador_tx dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .clk10     (clk10),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .data_ack  (data_ack),
    .is_k      (is_k),
    .align_err (align_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample #1 after the edge; pop the scoreboard on every enabled valid bit.
  task automatic cyc();
    logic       en;
    logic [1:0] e;
    en = enb & rst;
    @(posedge clk);
    #1;
    if (en && data_ack) ack_seen++;
    if (en && ser_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_bit actual=%0b expected=none t=%0t", ser_out, $time);
      end else begin
        e = sb.pop_front();
        check("ser_out", ser_out, e[0]);
        check("is_k", is_k, e[1]);
      end
    end
  endtask

  task automatic push_sym(input logic [7:0] s, input logic k, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) sb.push_back({k, s[i]});
  endtask

  // One aligned clk10 period (high 4, low 4 enabled cycles) carrying one symbol.
  task automatic byte_period(input vec_t v);
    data_in  = v.data;
    valid_in = v.valid;
    if (v.exp_vld) push_sym(v.exp_sym, v.exp_k, 8);
    if (v.valid) exp_acks++;
    for (int j = 0; j < 8; j++) begin
      clk10 = (j < 4);
      cyc();
      check("period_ser_valid", ser_valid, v.exp_vld);
      if (!v.exp_vld) check("period_ser_out_quiet", ser_out, 1'b0);
    end
  endtask

  task automatic check_all_zero();
    check("zero_ser_out", ser_out, 1'b0);
    check("zero_ser_valid", ser_valid, 1'b0);
    check("zero_data_ack", data_ack, 1'b0);
    check("zero_is_k", is_k, 1'b0);
    check("zero_align_err", align_err, 1'b0);
  endtask

  function automatic vec_t idle_vec(input logic [7:0] d);
    vec_t v;
    v.data  = d;
    v.valid = 1'b0;
`ifdef IDLE_COM_EN
    v.exp_sym = 8'hBC;
    v.exp_vld = 1'b1;
    v.exp_k   = 1'b1;
`else
    v.exp_sym = 8'h00;
    v.exp_vld = 1'b0;
    v.exp_k   = 1'b0;
`endif
    return v;
  endfunction

  function automatic vec_t data_vec(input logic [7:0] d);
    vec_t v;
    v.data    = d;
    v.valid   = 1'b1;
    v.exp_sym = d;
    v.exp_vld = 1'b1;
    v.exp_k   = 1'b0;
    return v;
  endfunction

  initial begin
    logic [7:0] pd;
    logic [7:0] md;

    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{8'h0F, 1'b1, 8'h0F, 1'b1, 1'b0};
    tbl[2] = '{8'hF0, 1'b1, 8'hF0, 1'b1, 1'b0};
    tbl[3] = idle_vec(8'h77);
    tbl[4] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[7] = idle_vec(8'hE1);

    // Reset for 3 cycles
    rst      = 1'b0;
    enb      = 1'b0;
    clk10    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) cyc();
    check_all_zero();
    rst = 1'b1;
    enb = 1'b1;
    cyc();
    cyc();
    check("idle_ser_valid", ser_valid, 1'b0);
    check("idle_ser_out", ser_out, 1'b0);

    // Aligned back-to-back symbol periods
    for (int i = 0; i < 8; i++) byte_period(tbl[i]);
    check("table_align_err", align_err, 1'b0);

    // Underrun: clk10 stays low, stream drops to idle
    clk10 = 1'b0;
    cyc();
    check("underrun_ser_valid", ser_valid, 1'b0);
    check("underrun_ser_out", ser_out, 1'b0);
    check("underrun_is_k", is_k, 1'b0);
    cyc();
    check("underrun_hold_valid", ser_valid, 1'b0);
    check("table_sb_empty", sb.size(), 0);
    check("table_ack_count", ack_seen, exp_acks);

    // enb pause mid-byte: output frozen, byte resumes intact
    pd       = 8'hC6;
    data_in  = pd;
    valid_in = 1'b1;
    push_sym(pd, 1'b0, 8);
    exp_acks++;
    clk10 = 1'b1;
    repeat (3) cyc();
    enb = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cyc();
      check("pause_ser_out", ser_out, pd[5]);
      check("pause_ser_valid", ser_valid, 1'b1);
      check("pause_data_ack", data_ack, 1'b0);
    end
    enb = 1'b1;
    cyc();
    clk10 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cyc();
      check("pause_tail_valid", ser_valid, 1'b1);
    end
    byte_period(data_vec(8'h69));
    check("pause_sb_empty", sb.size(), 0);
    check("pause_align_err", align_err, 1'b0);

    // Misaligned rise 5 cycles after a load: truncation and sticky align_err
    md       = 8'h96;
    data_in  = md;
    valid_in = 1'b1;
    push_sym(md, 1'b0, 5);
    exp_acks++;
    clk10 = 1'b1;
    repeat (3) cyc();
    clk10 = 1'b0;
    repeat (2) cyc();
    check("pre_misalign_err", align_err, 1'b0);
    data_in = 8'h3A;
    push_sym(8'h3A, 1'b0, 8);
    exp_acks++;
    clk10 = 1'b1;
    cyc();
    check("misalign_err_set", align_err, 1'b1);
    repeat (3) cyc();
    clk10 = 1'b0;
    repeat (4) cyc();
    check("misalign_sb_empty", sb.size(), 0);
    byte_period(data_vec(8'h5C));
    check("misalign_err_sticky", align_err, 1'b1);
    cyc();
    check("misalign_underrun_valid", ser_valid, 1'b0);
    check("misalign_ack_count", ack_seen, exp_acks);

    // Reset pulse mid-byte: outputs clear immediately, then recovery
    data_in  = 8'hE7;
    valid_in = 1'b1;
    push_sym(8'hE7, 1'b0, 8);
    exp_acks++;
    clk10 = 1'b1;
    repeat (4) cyc();
    clk10 = 1'b0;
    cyc();
    check("pre_reset_valid", ser_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero();
    sb.delete();
    cyc();
    cyc();
    check_all_zero();
    rst = 1'b1;
    byte_period(data_vec(8'h42));
    check("reset_recover_sb_empty", sb.size(), 0);
    check("reset_recover_align_err", align_err, 1'b0);
    check("final_ack_count", ack_seen, exp_acks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
